arduino_link_tx: RTL and testbench

//  FPGA->Arduino transmitter: the outbound counterpart of the GPIO_1 sensor/box-address input path.

---
 rtl/arduino_link_tx.sv | 137 +++++++++++++
 tb/tb_arduino_link_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arduino_link_tx.sv
// FPGA->Arduino link transmitter: shifts a 19-bit {sync, box, score, parity}
// frame out on gpio_sdata/gpio_sclk/gpio_frame, then waits for an ack edge.
module arduino_link_tx #(
  parameter int CLK_DIV     = 250,
  parameter int ACK_TIMEOUT = 50000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        send_valid,
  output logic        send_ready,
  input  logic [2:0]  box_in,
  input  logic [10:0] score_in,
  output logic        gpio_sdata,
  output logic        gpio_sclk,
  output logic        gpio_frame,
  input  logic        gpio_ack,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_error
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(ACK_TIMEOUT - 1);
  localparam logic [4:0]    LAST_BIT = 5'd18;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_ACK} state_t;

  state_t        state_q, state_d;
  logic [18:0]   shreg_q, shreg_d;
  logic [4:0]    bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic [TW-1:0] to_q, to_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          sync3_q, sync3_d;
  logic          rise_q, rise_d;

  // State and datapath registers; reset clears everything, dropping the
  // GPIO lines in the same cycle since they decode from these flops.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      to_q    <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      to_q    <= to_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      rise_q  <= rise_d;
    end
  end

  // Next-state: frame latch, bit-clock divider, shifter and ack wait.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    div_d    = div_q;
    sclk_d   = sclk_q;
    to_d     = to_q;
    tx_done  = 1'b0;
    tx_error = 1'b0;
    sync1_d  = gpio_ack;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    // Only edges seen while waiting count; a level held across entry
    // never produces an edge here.
    rise_d   = (state_q == WAIT_ACK) && sync2_q && !sync3_q;
    unique case (state_q)
      IDLE: begin
        if (send_valid) begin
          shreg_d = {4'b1010, box_in, score_in, ^{box_in, score_in}};
          bit_d   = '0;
          div_d   = '0;
          sclk_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (div_q == DIV_MAX) begin
          div_d  = '0;
          sclk_d = !sclk_q;
          if (sclk_q) begin
            if (bit_q == LAST_BIT) begin
              sclk_d  = 1'b0;
              to_d    = '0;
              state_d = WAIT_ACK;
            end else begin
              shreg_d = {shreg_q[17:0], 1'b0};
              bit_d   = bit_q + 5'd1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      WAIT_ACK: begin
        if (rise_q) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end else if (to_q == TO_MAX) begin
          tx_error = 1'b1;
          state_d  = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode straight from registered state.
  always_comb begin
    send_ready = (state_q == IDLE);
    busy       = (state_q != IDLE);
    gpio_frame = (state_q == SHIFT);
    gpio_sdata = (state_q == SHIFT) && shreg_q[18];
    gpio_sclk  = sclk_q;
  end

endmodule

// File: tb/tb_arduino_link_tx.sv
// Scoreboard bench for arduino_link_tx: frames and done/error results are
// queued at send time and checked by an independent negedge monitor.
module tb_arduino_link_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        send_valid = 1'b0;
  logic        send_ready;
  logic [2:0]  box_in = '0;
  logic [10:0] score_in = '0;
  logic        gpio_sdata, gpio_sclk, gpio_frame;
  logic        gpio_ack = 1'b0;
  logic        busy, tx_done, tx_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [18:0] exp_q[$];
  int          res_q[$];

  logic        in_frame = 1'b0;
  logic        prev_sclk = 1'b0;
  logic [18:0] cap = '0;
  logic [18:0] last_frame = '0;
  int          cap_n = 0;
  int          flen = 0;
  logic        hold_bad = 1'b0;

  always #5 clk = ~clk;

  arduino_link_tx #(.CLK_DIV(2), .ACK_TIMEOUT(20)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .send_valid(send_valid),
    .send_ready(send_ready),
    .box_in    (box_in),
    .score_in  (score_in),
    .gpio_sdata(gpio_sdata),
    .gpio_sclk (gpio_sclk),
    .gpio_frame(gpio_frame),
    .gpio_ack  (gpio_ack),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: rebuilds each frame from sclk rising edges and checks
  // done/error pulses against the result queue.
  always @(negedge clk) begin
    logic [18:0] e;
    int          r;
    if (reset) begin
      if (in_frame && exp_q.size() > 0) e = exp_q.pop_front();
      in_frame  = 1'b0;
      cap_n     = 0;
      prev_sclk = 1'b0;
    end else begin
      if (gpio_frame) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          cap      = '0;
          cap_n    = 0;
          flen     = 0;
          hold_bad = 1'b0;
        end
        flen++;
        if (!busy || send_ready) hold_bad = 1'b1;
        if (gpio_sclk && !prev_sclk) begin
          cap = {cap[17:0], gpio_sdata};
          cap_n++;
        end
      end else if (in_frame) begin
        in_frame   = 1'b0;
        last_frame = cap;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(cap), 32'h7ffff);
        end else begin
          e = exp_q.pop_front();
          check("frame_bits", 32'(cap), 32'(e));
        end
        check("frame_len", flen, 76);
        check("bit_count", cap_n, 19);
        check("busy_during_frame", 32'(hold_bad), 0);
        check("lines_after_frame", {gpio_sdata, gpio_sclk}, 0);
      end
      if (tx_done || tx_error) begin
        check("done_and_error", {tx_done, tx_error} == 2'b11, 0);
        if (res_q.size() == 0) begin
          check("unexpected_result", {tx_done, tx_error}, 0);
        end else begin
          r = res_q.pop_front();
          check("result_kind", tx_done ? 1 : 2, r);
        end
      end
      prev_sclk = gpio_sclk;
    end
  end

  task automatic send(input logic [2:0] b, input logic [10:0] s,
                      input logic [18:0] f, input int res,
                      input bit hold);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (send_ready) break;
    end
    check("ready_before_send", 32'(send_ready), 1);
    box_in     = b;
    score_in   = s;
    send_valid = 1'b1;
    exp_q.push_back(f);
    if (res != 0) res_q.push_back(res);
    @(negedge clk);
    if (!hold) begin
      send_valid = 1'b0;
      box_in     = ~b;
      score_in   = ~s;
    end
  endtask

  task automatic wait_frame(input logic want);
    int i;
    for (i = 0; i < 200; i++) begin
      if (gpio_frame == want) break;
      @(negedge clk);
    end
    check("frame_wait", 32'(gpio_frame), 32'(want));
  endtask

  task automatic count_pulse(input bit err, output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      if (err ? tx_error : tx_done) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic ack_after(input int dly);
    int n;
    wait_frame(1'b1);
    wait_frame(1'b0);
    repeat (dly) @(negedge clk);
    gpio_ack = 1'b1;
    @(negedge clk);
    count_pulse(1'b0, n);
    check("ack_latency", n, 2);
    gpio_ack = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("reset_outs",
          {send_ready, busy, gpio_frame, gpio_sclk, gpio_sdata,
           tx_done, tx_error}, 7'b1000000);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_outs",
          {send_ready, busy, gpio_frame, gpio_sclk, gpio_sdata,
           tx_done, tx_error}, 7'b1000000);

    // Basic frame, ack five cycles after frame end.
    send(3'd5, 11'd3, 19'b1010_101_00000000011_0, 1, 1'b0);
    ack_after(5);
    @(negedge clk);
    check("post_done_idle", {busy, send_ready}, 2'b01);

    // Odd payload weight: parity bit set.
    send(3'd1, 11'd0, 19'b1010_001_00000000000_1, 1, 1'b0);
    ack_after(1);
    check("last_bit_par", 32'(last_frame[0]), 1);

    // No ack at all: timeout.
    send(3'd6, 11'd1234, 19'b1010_110_10011010010_1, 2, 1'b0);
    wait_frame(1'b1);
    wait_frame(1'b0);
    count_pulse(1'b1, n);
    check("timeout_cycle", n, 19);
    @(negedge clk);
    check("post_err_idle", {busy, send_ready, tx_error}, 3'b010);

    // Ack already high before WAIT_ACK: still a timeout.
    gpio_ack = 1'b1;
    send(3'd3, 11'd5, 19'b1010_011_00000000101_0, 2, 1'b0);
    wait_frame(1'b1);
    wait_frame(1'b0);
    count_pulse(1'b1, n);
    check("held_ack_timeout", n, 19);
    gpio_ack = 1'b0;

    // Reset in the middle of a frame.
    send(3'd2, 11'd100, 19'b1010_010_00001100100_0, 0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (cap_n >= 7) break;
      @(negedge clk);
    end
    check("reached_bit7", cap_n >= 7, 1);
    #2 reset = 1'b1;
    #1 check("reset_mid_frame",
             {send_ready, busy, gpio_frame, gpio_sclk, gpio_sdata,
              tx_done, tx_error}, 7'b1000000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    send(3'd4, 11'h2AA, 19'b1010_100_01010101010_0, 1, 1'b0);
    ack_after(2);

    // valid held: second frame accepted right after tx_done.
    send(3'd7, 11'd2047, 19'b1010_111_11111111111_0, 1, 1'b1);
    exp_q.push_back(19'b1010_111_11111111111_0);
    res_q.push_back(1);
    ack_after(5);
    check("b2b_pulse_frame", {tx_done, gpio_frame}, 2'b10);
    @(negedge clk);
    check("b2b_ready", {send_ready, gpio_frame}, 2'b10);
    @(negedge clk);
    check("b2b_accept", {gpio_frame, busy}, 2'b11);
    send_valid = 1'b0;
    ack_after(3);

    repeat (10) @(negedge clk);
    check("frames_left", exp_q.size(), 0);
    check("results_left", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
